gaussian_conv: RTL and testbench

- Sequential multiply-accumulate Gaussian blur for one output pixel of the Oriented-FAST ISP pre-filter stage.
- Consumes one SIZE x SIZE window of 8-bit grayscale pixels, streamed in row-major order, one pixel per accepted beat.
- Applies a separable binomial kernel and emits one rounded 8-bit blurred pixel.
- Sits between the window/line-buffer fetch logic and the FAST corner detector.

---
 rtl/gaussian_conv_pkg.sv | 28 ++
 rtl/gaussian_coeff_rom.sv | 26 ++
 rtl/gaussian_conv.sv | 209 ++++++++++++++++++++
 tb/tb_gaussian_conv.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gaussian_conv_pkg.sv
// Shared types and elaboration helpers for the gaussian_conv blur block.
// Optional feature macro used by the top: GAUSSIAN_CONV_BYPASS_EN.
package gaussian_conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int MAX_SIZE = 7;

    // Binomial coefficient C(n,k); only ever evaluated on constants.
    function automatic int binom(input int n, input int k);
        int r;
        r = 1;
        for (int i = 0; i < k; i++) begin
            r = r * (n - i) / (i + 1);
        end
        return r;
    endfunction

    // 8 pixel bits plus log2 of the kernel weight sum.
    function automatic int acc_width(input int size);
        return 8 + 2 * (size - 1);
    endfunction

endpackage

// File: rtl/gaussian_coeff_rom.sv
// Combinational binomial kernel weight lookup: W(row,col) = B(row)*B(col).
module gaussian_coeff_rom
    import gaussian_conv_pkg::*;
#(
    parameter int SIZE = 3,
    parameter int WW   = 5
) (
    input  logic [2:0]    row_i,
    input  logic [2:0]    col_i,
    output logic [WW-1:0] weight_o
);

    logic [WW-1:0] b_tab [0:7];

    // Unused table slots hold zero so out-of-window indices give zero weight.
    for (genvar gk = 0; gk < 8; gk++) begin : g_tab
        if (gk < SIZE) begin : g_in
            assign b_tab[gk] = WW'(binom(SIZE - 1, gk));
        end else begin : g_out
            assign b_tab[gk] = '0;
        end
    end

    assign weight_o = b_tab[row_i] * b_tab[col_i];

endmodule

// File: rtl/gaussian_conv.sv
// Sequential MAC Gaussian blur of one SIZE x SIZE window into one rounded pixel.
// Define GAUSSIAN_CONV_BYPASS_EN to add a bypass port that outputs the centre pixel.
module gaussian_conv
    import gaussian_conv_pkg::*;
#(
    parameter logic [3:0] SIZE = 4'd3
) (
`ifdef GAUSSIAN_CONV_BYPASS_EN
    input  logic       bypass,
`endif
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_ready,
    output logic       busy,
    output logic       out_valid,
    output logic [7:0] out_pixel
);

    localparam int SZ = int'(SIZE);
    localparam int S  = 2 * (SZ - 1);
    localparam int AW = acc_width(SZ);
    localparam int WW = S + 1;
    localparam logic [2:0]  LAST = 3'(SZ - 1);
    localparam logic [2:0]  CTR  = 3'((SZ - 1) / 2);
    localparam logic [AW:0] HALF = (AW + 1)'(1) << (S - 1);

    if (!(SZ == 3 || SZ == 5 || SZ == 7)) begin : g_size_chk
        $error("gaussian_conv: SIZE must be 3, 5 or 7");
    end

    state_e          state_q, state_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [2:0]      row_q, row_d;
    logic [2:0]      col_q, col_d;
    logic [7:0]      out_pixel_q, out_pixel_d;
    logic            pix_ready_q, pix_ready_d;
    logic            busy_q, busy_d;
    logic            out_valid_q, out_valid_d;

    logic [WW-1:0]   weight_s;
    logic [AW-1:0]   prod_s;
    logic [AW-1:0]   acc_next_s;
    logic [AW:0]     rnd_s;
    logic [7:0]      blur_s;
    logic [7:0]      result_s;
    logic            beat_s;
    logic            last_s;

`ifdef GAUSSIAN_CONV_BYPASS_EN
    logic            bypass_q, bypass_d;
    logic [7:0]      center_q, center_d;
`endif

    gaussian_coeff_rom #(
        .SIZE (SZ),
        .WW   (WW)
    ) u_rom (
        .row_i    (row_q),
        .col_i    (col_q),
        .weight_o (weight_s)
    );

    assign beat_s = (state_q == ACCUM) && pix_valid;
    assign last_s = (row_q == LAST) && (col_q == LAST);

    // MAC and rounding; the final beat's product is folded in before rounding.
    always_comb begin
        prod_s     = AW'(pix_data) * AW'(weight_s);
        acc_next_s = acc_q + prod_s;
        rnd_s      = ({1'b0, acc_next_s} + HALF) >> S;
        if (rnd_s > (AW + 1)'(255)) begin
            blur_s = 8'hFF;
        end else begin
            blur_s = rnd_s[7:0];
        end
`ifdef GAUSSIAN_CONV_BYPASS_EN
        if (bypass_q) begin
            result_s = center_q;
        end else begin
            result_s = blur_s;
        end
`else
        result_s = blur_s;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = ACCUM;
                else       state_d = IDLE;
            end
            ACCUM: begin
                if (beat_s && last_s) state_d = DONE;
                else                  state_d = ACCUM;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so they leave a register.
    always_comb begin
        pix_ready_d = (state_d == ACCUM);
        busy_d      = (state_d == ACCUM) || (state_d == DONE);
        out_valid_d = (state_d == DONE);
    end

    // Datapath next-state: counters, accumulator and result capture.
    always_comb begin
        acc_d       = acc_q;
        row_d       = row_q;
        col_d       = col_q;
        out_pixel_d = out_pixel_q;
`ifdef GAUSSIAN_CONV_BYPASS_EN
        bypass_d    = bypass_q;
        center_d    = center_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    row_d = 3'd0;
                    col_d = 3'd0;
`ifdef GAUSSIAN_CONV_BYPASS_EN
                    bypass_d = bypass;
`endif
                end else begin
                    acc_d = acc_q;
                end
            end
            ACCUM: begin
                if (beat_s) begin
                    acc_d = acc_next_s;
`ifdef GAUSSIAN_CONV_BYPASS_EN
                    if ((row_q == CTR) && (col_q == CTR)) begin
                        center_d = pix_data;
                    end else begin
                        center_d = center_q;
                    end
`endif
                    if (last_s) begin
                        row_d       = 3'd0;
                        col_d       = 3'd0;
                        out_pixel_d = result_s;
                    end else if (col_q == LAST) begin
                        row_d = row_q + 3'd1;
                        col_d = 3'd0;
                    end else begin
                        col_d = col_q + 3'd1;
                    end
                end else begin
                    acc_d = acc_q;
                end
            end
            DONE:    acc_d = acc_q;
            default: acc_d = acc_q;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_q       <= '0;
            row_q       <= 3'd0;
            col_q       <= 3'd0;
            out_pixel_q <= 8'd0;
            pix_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef GAUSSIAN_CONV_BYPASS_EN
            bypass_q    <= 1'b0;
            center_q    <= 8'd0;
`endif
        end else begin
            acc_q       <= acc_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_pixel_q <= out_pixel_d;
            pix_ready_q <= pix_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
`ifdef GAUSSIAN_CONV_BYPASS_EN
            bypass_q    <= bypass_d;
            center_q    <= center_d;
`endif
        end
    end

    assign pix_ready = pix_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;

endmodule

// File: tb/tb_gaussian_conv.sv
// Table-driven scoreboard bench for gaussian_conv at SIZE 3, 5 and 7.
// Bypass vectors are added when GAUSSIAN_CONV_BYPASS_EN is defined.
module tb_gaussian_conv;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic [2:0] start_v;
    logic [2:0] rdy_v, busy_v, ov_v;
    logic [7:0] op_v [3];
`ifdef GAUSSIAN_CONV_BYPASS_EN
    logic       bypass;
`endif

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        gaussian_conv #(.SIZE(4'(3 + 2 * gi))) dut (
`ifdef GAUSSIAN_CONV_BYPASS_EN
            .bypass    (bypass),
`endif
            .clk       (clk),
            .n_rst     (n_rst),
            .start     (start_v[gi]),
            .pix_valid (pix_valid),
            .pix_data  (pix_data),
            .pix_ready (rdy_v[gi]),
            .busy      (busy_v[gi]),
            .out_valid (ov_v[gi]),
            .out_pixel (op_v[gi])
        );
    end

    typedef struct { int dut; int expv; } sb_t;
    typedef struct {
        int    dut;
        int    pat;
        int    fill;
        bit    gaps;
        bit    midst;
        bit    byp;
        int    expv;
        string nm;
    } vec_t;

    sb_t  sb_q [$];
    vec_t vecs [$];
    int   wpix [49];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int bw(input int size, input int k);
        int b3 [3] = '{1, 2, 1};
        int b5 [5] = '{1, 4, 6, 4, 1};
        int b7 [7] = '{1, 6, 15, 20, 15, 6, 1};
        case (size)
            3:       return b3[k];
            5:       return b5[k];
            default: return b7[k];
        endcase
    endfunction

    // pat: 0 flat fill, 1 ramp, 2 centre impulse, 3 top-left corner, 4 random
    function automatic void build(input int size, input int pat, input int fill);
        int ctr;
        ctr = (size * size) / 2;
        for (int i = 0; i < 49; i++) begin
            case (pat)
                0:       wpix[i] = fill;
                1:       wpix[i] = i;
                2:       wpix[i] = (i == ctr) ? fill : 0;
                3:       wpix[i] = (i == 0) ? fill : 0;
                default: wpix[i] = int'($urandom_range(255, 0));
            endcase
        end
    endfunction

    function automatic int model(input int size, input bit byp);
        int sum, s, res;
        if (byp) return wpix[(size * size) / 2];
        sum = 0;
        s   = 2 * (size - 1);
        for (int r = 0; r < size; r++)
            for (int c = 0; c < size; c++)
                sum += wpix[r * size + c] * bw(size, r) * bw(size, c);
        res = (sum + (1 << (s - 1))) >> s;
        return (res > 255) ? 255 : res;
    endfunction

    // Scoreboard: every out_valid pops one expected result.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (ov_v[k] === 1'b1) begin : pop_blk
                sb_t e;
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_out_valid dut%0d: got pixel %0d, expected no output", k, op_v[k]);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("result_dut%0d", k), op_v[k], e.expv);
                    check($sformatf("result_src_dut%0d", k), k, e.dut);
                end
            end
        end
    end

    task automatic drive(input int sel, input bit gaps, input bit midst, input bit byp, input bit measure);
        int size, cyc;
        size = 3 + 2 * sel;
        check("idle_ready", rdy_v[sel], 0);
`ifdef GAUSSIAN_CONV_BYPASS_EN
        bypass = byp;
`endif
        start_v[sel] = 1'b1;
        cyc = 1;
        @(negedge clk); cyc++;
        start_v[sel] = 1'b0;
`ifdef GAUSSIAN_CONV_BYPASS_EN
        bypass = ~byp;
`endif
        check("accum_busy", busy_v[sel], 1);
        for (int i = 0; i < size * size; i++) begin
            if (gaps) begin
                pix_valid = 1'b0;
                pix_data  = 8'($urandom);
                @(negedge clk); cyc++;
                check("gap_ready", rdy_v[sel], 1);
            end
            pix_valid = 1'b1;
            pix_data  = 8'(wpix[i]);
            if (midst && i == 3) start_v[sel] = 1'b1;
            @(negedge clk); cyc++;
            start_v[sel] = 1'b0;
        end
        pix_valid = 1'b0;
        for (int w = 0; w < 30 && ov_v[sel] !== 1'b1; w++) begin
            @(negedge clk); cyc++;
        end
        check("out_valid_seen", ov_v[sel], 1);
        if (measure) check("latency_cycles", cyc, size * size + 2);
        check("done_ready", rdy_v[sel], 0);
        check("done_busy", busy_v[sel], 1);
        @(negedge clk);
        check("out_valid_one_cycle", ov_v[sel], 0);
        check("idle_busy", busy_v[sel], 0);
    endtask

    task automatic run_vec(input vec_t v, input bit measure);
        int ev;
        build(3 + 2 * v.dut, v.pat, v.fill);
        ev = (v.expv < 0) ? model(3 + 2 * v.dut, v.byp) : v.expv;
        sb_q.push_back('{v.dut, ev});
        drive(v.dut, v.gaps, v.midst, v.byp, measure);
    endtask

    initial begin
        n_rst     = 1'b0;
        start_v   = 3'b000;
        pix_valid = 1'b0;
        pix_data  = 8'd0;
`ifdef GAUSSIAN_CONV_BYPASS_EN
        bypass    = 1'b0;
`endif
        vecs.push_back('{0, 0, 100, 1'b0, 1'b0, 1'b0, 100, "all100"});
        vecs.push_back('{0, 2, 255, 1'b0, 1'b0, 1'b0, 64,  "impulse3"});
        vecs.push_back('{0, 1, 0,   1'b0, 1'b0, 1'b0, 4,   "ramp3"});
        vecs.push_back('{0, 3, 16,  1'b0, 1'b0, 1'b0, 1,   "corner16"});
        vecs.push_back('{0, 1, 0,   1'b1, 1'b0, 1'b0, 4,   "ramp_gaps"});
        vecs.push_back('{0, 1, 0,   1'b0, 1'b1, 1'b0, 4,   "ramp_midstart"});
        vecs.push_back('{1, 0, 255, 1'b0, 1'b0, 1'b0, 255, "all255_5"});
        vecs.push_back('{2, 0, 255, 1'b0, 1'b0, 1'b0, 255, "all255_7"});
        vecs.push_back('{1, 2, 255, 1'b0, 1'b0, 1'b0, 36,  "impulse5"});
        for (int k = 0; k < 3; k++) begin
            vecs.push_back('{k, 4, 0, 1'b0, 1'b0, 1'b0, -1, "rand"});
            vecs.push_back('{k, 4, 0, 1'b1, 1'b0, 1'b0, -1, "rand_gaps"});
        end
`ifdef GAUSSIAN_CONV_BYPASS_EN
        vecs.push_back('{0, 1, 0,   1'b0, 1'b0, 1'b1, 4,   "bypass_ramp3"});
        vecs.push_back('{0, 2, 255, 1'b0, 1'b0, 1'b1, 255, "bypass_impulse3"});
        vecs.push_back('{2, 1, 0,   1'b0, 1'b0, 1'b1, 24,  "bypass_ramp7"});
        vecs.push_back('{1, 4, 0,   1'b1, 1'b0, 1'b1, -1,  "bypass_rand5"});
`endif

        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("reset_ready", rdy_v[k], 0);
            check("reset_busy", busy_v[k], 0);
            check("reset_out_valid", ov_v[k], 0);
            check("reset_out_pixel", op_v[k], 0);
        end
        n_rst = 1'b1;
        @(negedge clk);

        for (int v = 0; v < vecs.size(); v++) begin
            run_vec(vecs[v], v == 0);
        end

        // Abort a window with reset after four beats; nothing may come out of it.
        build(3, 0, 100);
        sb_q.push_back('{0, 100});
        drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pix_valid = 1'b1;
            pix_data  = 8'd50;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        n_rst = 1'b0;
        #1;
        check("abort_out_pixel", op_v[0], 0);
        check("abort_busy", busy_v[0], 0);
        check("abort_ready", rdy_v[0], 0);
        check("abort_out_valid", ov_v[0], 0);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (15) @(negedge clk);
        run_vec('{0, 0, 200, 1'b0, 1'b0, 1'b0, 200, "after_abort"}, 1'b1);

        // Beats offered while idle must be refused and not leak into the next window.
        pix_valid = 1'b1;
        pix_data  = 8'd255;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_refuse_ready", rdy_v[0], 0);
        end
        pix_valid = 1'b0;
        run_vec('{0, 1, 0, 1'b0, 1'b0, 1'b0, 4, "ramp_after_idle_beats"}, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
